// File: rtl/serial_pkg.sv
// Shared types for the serial receiver: FSM state encoding and parity mode.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_t;

  localparam parity_mode_t PARITY_MODE = PAR_ODD;

endpackage

// File: rtl/rx_shifter.sv
// N-bit serial-in/parallel-out register; LSB_FIRST picks which end the first bit lands in.
module rx_shifter #(
  parameter int N         = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         din,
  output logic [N-1:0] q
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values;
  // this register is also reset explicitly because its contents are observable after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (shift_en) begin
      if (LSB_FIRST != 0) q <= {din, q[N-1:1]};
      else                q <= {q[N-2:0], din};
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Serial frame receiver: start, N data bits, parity, stop; one-word holding register with overrun.
module serial_rx
  import serial_pkg::*;
#(
  parameter int N         = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         bit_en,
  input  logic         clr,
  input  logic         rx_ready,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun
);

  localparam int CW = $clog2(N);

  rx_state_t       state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    shreg;
  logic            par_bit;
  logic            shift_en, cnt_clr, par_cap, deliver, frame_bad;
  logic            load, drop, word_perr;

  rx_shifter #(.N(N), .LSB_FIRST(LSB_FIRST)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (sin),
    .q        (shreg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      par_bit <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)       cnt <= '0;
      else if (shift_en) cnt <= cnt + 1'b1;
      if (par_cap) par_bit <= sin;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    par_cap   = 1'b0;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: if (!sin) begin
          state_nxt = DATA;
          cnt_clr   = 1'b1;
        end
        DATA: begin
          shift_en = 1'b1;
          if (cnt == CW'(N - 1)) state_nxt = PARITY;
        end
        PARITY: begin
          par_cap   = 1'b1;
          state_nxt = STOP;
        end
        STOP: if (sin) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end else begin
          frame_bad = 1'b1;
          state_nxt = WAIT_HIGH;
        end
        WAIT_HIGH: if (sin) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Error when the data+parity ones count does not match the configured parity sense.
  assign word_perr = (^{shreg, par_bit}) ^ (PARITY_MODE == PAR_ODD);
  assign load      = deliver & (~rx_valid | rx_ready);
  assign drop      = deliver & rx_valid & ~rx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      if (load) begin
        rx_data    <= shreg;
        parity_err <= word_perr;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // A drop in the same clock as clr keeps the flag set.
      if (drop)     overrun <= 1'b1;
      else if (clr) overrun <= 1'b0;
    end
  end

endmodule
